// File: rtl/hc_path_pkg.sv
// Shared types and helpers for the hypercube path streamer.
// The optional request check is enabled by defining HC_PATH_CHK_EN.
package hc_path_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  function automatic int dimw_f(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  function automatic int lenw_f(input int dim);
    return $clog2(dim + 1);
  endfunction

  function automatic int gw_f(input int max_grp);
    return $clog2(max_grp + 1);
  endfunction

  // Extracts group g's w-bit field from a packed per-group vector.
  function automatic logic [31:0] field_get(input logic [63:0] vec, input int g, input int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return 32'((vec >> (g * w)) & m);
  endfunction

endpackage

// File: rtl/hc_path_stream_if.sv
// Request/hop bus of hc_path_stream. Valid/ready: a transfer happens on a rising
// edge where both are high; the sender holds payload and valid stable until then.
interface hc_path_stream_if
  import hc_path_pkg::*;
#(
  parameter int DIM     = 4,
  parameter int MAX_GRP = 3
);
  localparam int DIMW = dimw_f(DIM);
  localparam int LENW = lenw_f(DIM);
  localparam int GW   = gw_f(MAX_GRP);

  logic                    req_valid;
  logic                    req_ready;
  logic [DIM-1:0]          req_src;
  logic [GW-1:0]           req_ngrp;
  logic [MAX_GRP*LENW-1:0] req_len;
  logic [MAX_GRP*DIMW-1:0] req_base;
  logic [MAX_GRP*DIMW-1:0] req_exit;
  logic [MAX_GRP-1:0]      req_exit_en;
  logic                    hop_valid;
  logic                    hop_ready;
  logic [DIMW-1:0]         hop_dim;
  logic [DIM-1:0]          hop_node;
  logic [GW-1:0]           hop_grp;
  logic                    hop_last;
  logic                    done;
  logic                    err;
  state_e                  dbg_state;

  modport slave (
    input  req_valid, req_src, req_ngrp, req_len, req_base, req_exit, req_exit_en, hop_ready,
    output req_ready, hop_valid, hop_dim, hop_node, hop_grp, hop_last, done, err, dbg_state
  );

  modport master (
    output req_valid, req_src, req_ngrp, req_len, req_base, req_exit, req_exit_en, hop_ready,
    input  req_ready, hop_valid, hop_dim, hop_node, hop_grp, hop_last, done, err, dbg_state
  );
endinterface

// File: rtl/hc_ctz.sv
// Combinational count-trailing-zeros; a zero input yields 0.
module hc_ctz #(
  parameter int W  = 8,
  parameter int OW = 4
) (
  input  logic [W-1:0]  i_val,
  output logic [OW-1:0] o_cnt
);
  always_comb begin
    o_cnt = '0;
    for (int b = W - 1; b >= 0; b--) begin
      if (i_val[b]) o_cnt = OW'(b);
    end
  end
endmodule

// File: rtl/hc_path_stream.sv
// Streams a multi-group Gray-code hypercube path one registered hop per cycle.
// Define HC_PATH_CHK_EN to reject out-of-range requests with an err pulse.
module hc_path_stream
  import hc_path_pkg::*;
#(
  parameter int DIM     = 4,
  parameter int MAX_GRP = 3
) (
  input logic             clk,
  input logic             rst_n,
  hc_path_stream_if.slave bus
);
  localparam int DIMW = dimw_f(DIM);
  localparam int LENW = lenw_f(DIM);
  localparam int GW   = gw_f(MAX_GRP);
  localparam int IW   = 1 << LENW;
  localparam int DW   = DIMW + LENW;

  state_e                  r_state, w_next;
  logic [MAX_GRP*LENW-1:0] r_len, w_len;
  logic [MAX_GRP*DIMW-1:0] r_base, r_exit, w_base, w_exit;
  logic [MAX_GRP-1:0]      r_exit_en, w_exit_en;
  logic [GW-1:0]           r_ngrp, w_ngrp, r_g, w_g;
  logic [IW-1:0]           r_i, w_i, w_ip1;
  logic [DIM-1:0]          r_node, w_node, w_new_node;
  logic                    r_hop_valid, r_hop_last;
  logic [DIMW-1:0]         r_hop_dim, w_cur_base, w_cur_exit, w_d;
  logic [DIM-1:0]          r_hop_node;
  logic [GW-1:0]           r_hop_grp;
  logic [LENW-1:0]         w_cur_len, w_ctz;
  logic [DW-1:0]           w_d_raw;
  logic [IW:0]             w_cur_nh, w_pow;
  logic w_idle, w_accept, w_hs, w_load, w_bad;
  logic w_g_act, w_more, w_intra, w_has_hop, w_grp_end, w_last;

  // In IDLE the generator looks straight at the request so the first hop
  // can be registered on the acceptance edge.
  assign w_idle    = (r_state == IDLE);
  assign w_accept  = w_idle && bus.req_valid;
  assign w_hs      = r_hop_valid && bus.hop_ready;
  assign w_len     = w_idle ? bus.req_len     : r_len;
  assign w_base    = w_idle ? bus.req_base    : r_base;
  assign w_exit    = w_idle ? bus.req_exit    : r_exit;
  assign w_exit_en = w_idle ? bus.req_exit_en : r_exit_en;
  assign w_ngrp    = w_idle ? bus.req_ngrp    : r_ngrp;
  assign w_g       = w_idle ? '0              : r_g;
  assign w_i       = w_idle ? '0              : r_i;
  assign w_node    = w_idle ? bus.req_src     : r_node;
  assign w_ip1     = w_i + IW'(1);

  always_comb begin : grp_sel
    logic [LENW-1:0] l;
    logic [IW:0]     nh;
    l          = '0;
    nh         = '0;
    w_cur_len  = '0;
    w_cur_base = '0;
    w_cur_exit = '0;
    w_cur_nh   = '0;
    w_g_act    = 1'b0;
    w_more     = 1'b0;
    for (int g = 0; g < MAX_GRP; g++) begin
      l  = LENW'(field_get(64'(w_len), g, LENW));
      nh = ((IW+1)'(1) << l) - (IW+1)'(1) + (IW+1)'(w_exit_en[g]);
      if (g < int'(w_ngrp)) begin
        if (GW'(g) == w_g) begin
          w_g_act    = 1'b1;
          w_cur_len  = l;
          w_cur_base = DIMW'(field_get(64'(w_base), g, DIMW));
          w_cur_exit = DIMW'(field_get(64'(w_exit), g, DIMW));
          w_cur_nh   = nh;
        end else if (GW'(g) > w_g && nh != '0) begin
          w_more = 1'b1;
        end
      end
    end
  end

  hc_ctz #(.W(IW), .OW(LENW)) u_ctz (.i_val(w_ip1), .o_cnt(w_ctz));

  assign w_pow      = (IW+1)'(1) << w_cur_len;
  assign w_intra    = {1'b0, w_ip1} < w_pow;
  assign w_d_raw    = w_intra ? (DW'(w_cur_base) + DW'(w_ctz)) : DW'(w_cur_exit);
  assign w_d        = (w_d_raw >= DW'(DIM)) ? '0 : DIMW'(w_d_raw);
  assign w_new_node = w_node ^ (DIM'(1) << w_d);
  assign w_has_hop  = w_g_act && ({1'b0, w_i} < w_cur_nh);
  assign w_grp_end  = ({1'b0, w_ip1} == w_cur_nh);
  assign w_last     = w_grp_end && !w_more;
  assign w_load     = w_has_hop && (!r_hop_valid || bus.hop_ready) &&
                      ((w_accept && !w_bad) || (r_state == RUN));

`ifdef HC_PATH_CHK_EN
  logic r_err;

  always_comb begin : chk
    w_bad = (int'(bus.req_ngrp) > MAX_GRP);
    for (int g = 0; g < MAX_GRP; g++) begin
      if (g < int'(bus.req_ngrp)) begin
        if (int'(field_get(64'(bus.req_base), g, DIMW)) +
            int'(field_get(64'(bus.req_len), g, LENW)) > DIM) w_bad = 1'b1;
        if (bus.req_exit_en[g] && int'(field_get(64'(bus.req_exit), g, DIMW)) >= DIM) w_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_accept && w_bad;
  end

  assign bus.err = r_err;
`else
  assign w_bad   = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept && !w_bad) w_next = RUN;
      RUN:     if ((w_hs && r_hop_last) || (!r_hop_valid && !w_g_act)) w_next = FIN;
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0; r_base <= '0; r_exit <= '0; r_exit_en <= '0; r_ngrp <= '0;
      r_g <= '0; r_i <= '0; r_node <= '0;
      r_hop_valid <= 1'b0; r_hop_last <= 1'b0;
      r_hop_dim <= '0; r_hop_node <= '0; r_hop_grp <= '0;
    end else begin
      if (w_accept) begin
        r_len <= bus.req_len; r_base <= bus.req_base; r_exit <= bus.req_exit;
        r_exit_en <= bus.req_exit_en; r_ngrp <= bus.req_ngrp;
      end
      // Generator position moves when a hop enters the output register;
      // a zero-hop group is skipped in one idle cycle.
      if (w_load) begin
        r_node <= w_new_node;
        r_g    <= w_grp_end ? w_g + GW'(1) : w_g;
        r_i    <= w_grp_end ? '0 : w_ip1;
      end else if (w_accept) begin
        r_g <= '0; r_i <= '0; r_node <= bus.req_src;
      end else if (r_state == RUN && !w_has_hop && w_g_act) begin
        r_g <= r_g + GW'(1); r_i <= '0;
      end
      if (w_load) begin
        r_hop_valid <= 1'b1;
        r_hop_dim   <= w_d;
        r_hop_node  <= w_new_node;
        r_hop_grp   <= w_g;
        r_hop_last  <= w_last;
      end else if (w_hs) begin
        r_hop_valid <= 1'b0;
        r_hop_last  <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_idle;
  assign bus.hop_valid = r_hop_valid;
  assign bus.hop_dim   = r_hop_dim;
  assign bus.hop_node  = r_hop_node;
  assign bus.hop_grp   = r_hop_grp;
  assign bus.hop_last  = r_hop_last;
  assign bus.done      = (r_state == FIN);
  assign bus.dbg_state = r_state;
endmodule
